sram_dualport_ctrl: RTL and testbench
=====================================

SRAM_DUALPORT_CTRL -- requirements
Module: sram_dualport_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, giving the SRAM strobe length in clocks; legal range 1..15; WAIT_CYCLES x Tclk SHALL be at least 45 ns.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 a_req  in  1  port A (CPU) request level.
REQ-005 a_we  in  1  port A 1 = write, 0 = read.
REQ-006 a_addr  in  10  port A address.
REQ-007 a_din  in  8  port A write data.
REQ-008 a_dout  out  8  port A read data, registered.
REQ-009 a_ack  out  1  port A one-cycle completion pulse.
REQ-010 b_req  in  1  port B (video, read-only) request level.
REQ-011 b_addr  in  10  port B address.
REQ-012 b_dout  out  8  port B read data, registered.
REQ-013 b_ack  out  1  port B one-cycle completion pulse.
REQ-014 sram_a  out  10  SRAM address.
REQ-015 sram_d  inout  8  SRAM data; driven only during writes, otherwise high-Z.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS and DONE.
REQ-018 In IDLE with any req high, the FSM SHALL latch port, address, we and data, then go to SETUP; with no req it SHALL stay in IDLE.
REQ-019 Arbitration: a lone requester SHALL be granted; with both req high, the port not granted last SHALL be granted; last_grant SHALL update on every grant.
REQ-020 SETUP, 1 cycle: sram_a = latched addr; ce_n = 0; oe_n = 1; we_n = 1; for a write, sram_d driven with the latched data.
REQ-021 ACCESS, exactly WAIT_CYCLES cycles (4-bit down-counter): for a read, oe_n = 0; for a write, we_n = 0 with sram_d still driven; ce_n = 0 throughout.
REQ-022 On the edge leaving ACCESS, a read SHALL capture sram_d into a_dout or b_dout of the granted port.
REQ-023 DONE, 1 cycle: oe_n = 1; we_n = 1; ce_n = 0; for a write, sram_d held driven (data hold time); the granted port's ack = 1; next state IDLE.
REQ-024 Latency from the grant edge to ack high SHALL be WAIT_CYCLES + 2 cycles; minimum spacing between grants SHALL be WAIT_CYCLES + 3 cycles.
REQ-025 In IDLE: ce_n = oe_n = we_n = 1; sram_d high-Z; sram_a holds its last value.
REQ-026 oe_n = 0 and sram_d driven SHALL never coincide; we_n = 0 and oe_n = 0 SHALL never coincide.
REQ-027 Requesters SHALL hold req, addr and data stable until ack; a req still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-028 Port A writes SHALL not alter a_dout; each dout SHALL hold until that port's next read completes.
REQ-029 A b_req with the latched we forced to 0 SHALL be a read; port B has no write path.
REQ-030 Addresses 0x000..0x3FF are all valid; no wrap or translation is applied.

Reset
REQ-031 rst high at any edge, including mid-transaction, SHALL give: state IDLE; ce_n = oe_n = we_n = 1; sram_d high-Z; a_ack = b_ack = 0; a_dout = b_dout = 0x00; sram_a = 0x000; counter = 0; last_grant = A.
REQ-032 A transaction aborted by reset SHALL produce no ack and SHALL not be resumed.

Verification
REQ-033 The bench SHALL use a 45 ns async SRAM model, a 20 ns clock and WAIT_CYCLES = 3.
REQ-034 Reset with both req high -> while rst is high, all strobes 1, sram_d Z, acks 0, douts 0x00.
REQ-035 A write 0x155 <- 0xA5, then A read 0x155 -> we_n low exactly 3 cycles, a_ack 5 cycles after each grant, a_dout = 0xA5.
REQ-036 a_req and b_req raised together after reset, b_addr = 0x155 -> B granted first with b_dout = 0xA5, then A granted; holding both req high -> grants alternate A, B, A.
REQ-037 rst pulsed in the 2nd ACCESS cycle of an A write 0x3FF <- 0x5A -> we_n = 1 and sram_d Z on the next edge, no a_ack, location 0x3FF unchanged.
REQ-038 Writes 0x000 <- 0x11 and 0x3FF <- 0xEE, then read back both -> 0x11 and 0xEE, no aliasing; oe_n and a driven sram_d never overlap (assertion).

Source files
------------

// File: rtl/sram_dualport_ctrl_if.sv
// Request/response bundle for the two SRAM requesters: port A (CPU, read/write)
// and port B (video, read-only).
interface sram_dualport_ctrl_if;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic          a_ack;

    logic          b_req;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;
    logic          b_ack;

    modport master (
        output a_req, a_we, a_addr, a_din, b_req, b_addr,
        input  a_dout, a_ack, b_dout, b_ack
    );

    modport slave (
        input  a_req, a_we, a_addr, a_din, b_req, b_addr,
        output a_dout, a_ack, b_dout, b_ack
    );
endinterface

// File: rtl/sram_dualport_ctrl.sv
// Two-port arbiter in front of an asynchronous SRAM: round-robin grant, then a
// SETUP / ACCESS (WAIT_CYCLES long) / DONE strobe sequence with registered pins.
module sram_dualport_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_dualport_ctrl_if.slave  bus,
    output logic [9:0]           sram_a,
    inout  wire  [7:0]           sram_d,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          last_b_q,  last_b_d;
    logic          port_b_q,  port_b_d;
    logic          we_q,      we_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [AW-1:0] sram_a_q,  sram_a_d;
    logic          ce_n_q,    ce_n_d;
    logic          oe_n_q,    oe_n_d;
    logic          we_n_q,    we_n_d;
    logic          sram_d_oe_q, sram_d_oe_d;
    logic [DW-1:0] a_dout_q,  a_dout_d;
    logic [DW-1:0] b_dout_q,  b_dout_d;
    logic          a_ack_q,   a_ack_d;
    logic          b_ack_q,   b_ack_d;
    logic          grant_b;

    // Next-state and next-pin logic; every pin is computed one cycle ahead so it
    // leaves a flop aligned with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        port_b_d    = port_b_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sram_a_d    = sram_a_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        sram_d_oe_d = sram_d_oe_q;
        a_dout_d    = a_dout_q;
        b_dout_d    = b_dout_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        grant_b     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ce_n_d      = 1'b1;
                oe_n_d      = 1'b1;
                we_n_d      = 1'b1;
                sram_d_oe_d = 1'b0;
                if (bus.a_req || bus.b_req) begin
                    // B wins when alone, or when both ask and A was served last
                    grant_b     = bus.b_req && !(bus.a_req && last_b_q);
                    last_b_d    = grant_b;
                    port_b_d    = grant_b;
                    addr_d      = grant_b ? bus.b_addr : bus.a_addr;
                    we_d        = grant_b ? 1'b0 : bus.a_we;
                    wdata_d     = bus.a_din;
                    sram_a_d    = grant_b ? bus.b_addr : bus.a_addr;
                    ce_n_d      = 1'b0;
                    sram_d_oe_d = !grant_b && bus.a_we;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CW'(WAIT_CYCLES);
                oe_n_d  = we_q;
                we_n_d  = !we_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    a_ack_d = !port_b_q;
                    b_ack_d = port_b_q;
                    if (!we_q) begin
                        if (port_b_q) b_dout_d = sram_d;
                        else          a_dout_d = sram_d;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                ce_n_d      = 1'b1;
                sram_d_oe_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_b_q    <= 1'b0;
            port_b_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sram_a_q    <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            sram_d_oe_q <= 1'b0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            port_b_q    <= port_b_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sram_a_q    <= sram_a_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            sram_d_oe_q <= sram_d_oe_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
        end
    end

    assign sram_d     = sram_d_oe_q ? wdata_q : {DW{1'bz}};
    assign sram_a     = sram_a_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign bus.a_dout = a_dout_q;
    assign bus.b_dout = b_dout_q;
    assign bus.a_ack  = a_ack_q;
    assign bus.b_ack  = b_ack_q;
endmodule

// File: tb/tb_sram_dualport_ctrl.sv
// Bench for sram_dualport_ctrl: 45 ns async SRAM model, transaction-level
// reference model compared every cycle, directed scenarios plus random traffic.
module tb_sram_dualport_ctrl;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sram_a;
    wire  [7:0] sram_d;
    logic       sram_ce_n, sram_oe_n, sram_we_n;

    sram_dualport_ctrl_if bus();

    sram_dualport_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        $display("FAIL %s: got no ack within bound, expected ack at %0t", name, $time);
    endtask

    // ---------------- asynchronous SRAM, 45 ns access / write pulse ----------------
    logic [7:0] smem [1024];
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data;
    logic [9:0] wr_a = '0;
    logic [7:0] wr_d = '0;
    time        we_fall_t = 0;
    wire        rd_drive = !sram_oe_n && !sram_ce_n;

    always_comb rd_data = rd_valid ? smem[sram_a] : ~smem[sram_a];
    assign sram_d = rd_drive ? rd_data : 8'hzz;

    initial forever begin
        @(negedge sram_oe_n);
        rd_valid = 1'b0;
        #45;
        rd_valid = !sram_oe_n;
    end

    initial forever begin
        @(negedge sram_we_n);
        we_fall_t = $time;
    end

    initial forever begin
        @(negedge clk);
        if (!sram_we_n && !sram_ce_n) begin
            wr_a = sram_a;
            wr_d = sram_d;
        end
    end

    // A write only lands if the we_n pulse lasted the full 45 ns
    initial forever begin
        @(posedge sram_we_n);
        if ($time - we_fall_t >= 45) smem[wr_a] = wr_d;
    end

    // ---------------- reference model ----------------
    // k = cycles since the grant edge (0 = idle); SETUP is 1, ACCESS 2..W+1, DONE W+2.
    int         k = 0;
    logic       m_b = 1'b0, m_we = 1'b0, m_lastb = 1'b0;
    logic [9:0] m_addr = '0, m_sa = '0;
    logic [7:0] m_din = '0, m_adout = '0, m_bdout = '0;
    logic [7:0] mmem [1024];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            k = 0; m_lastb = 1'b0; m_adout = '0; m_bdout = '0; m_sa = '0;
        end else if (k == 0) begin
            if (bus.a_req || bus.b_req) begin
                if (bus.a_req && bus.b_req) m_b = !m_lastb;
                else                        m_b = bus.b_req;
                m_lastb = m_b;
                m_addr  = m_b ? bus.b_addr : bus.a_addr;
                m_we    = m_b ? 1'b0 : bus.a_we;
                m_din   = bus.a_din;
                m_sa    = m_addr;
                k       = 1;
            end
        end else if (k == W + 1) begin
            if (m_we)     mmem[m_addr] = m_din;
            else if (m_b) m_bdout = mmem[m_addr];
            else          m_adout = mmem[m_addr];
            k = W + 2;
        end else if (k == W + 2) begin
            k = 0;
        end else begin
            k = k + 1;
        end
    end

    task automatic compare_cycle();
        logic in_access, drv;
        in_access = (k >= 2) && (k <= W + 1);
        drv       = dut.sram_d_oe_q;
        check("ce_n",   32'(sram_ce_n), 32'(k == 0));
        check("oe_n",   32'(sram_oe_n), 32'(!(in_access && !m_we)));
        check("we_n",   32'(sram_we_n), 32'(!(in_access && m_we)));
        check("d_drive", 32'(drv), 32'((k >= 1) && m_we));
        check("sram_a", 32'(sram_a), 32'(m_sa));
        check("a_ack",  32'(bus.a_ack), 32'((k == W + 2) && !m_b));
        check("b_ack",  32'(bus.b_ack), 32'((k == W + 2) && m_b));
        check("a_dout", 32'(bus.a_dout), 32'(m_adout));
        check("b_dout", 32'(bus.b_dout), 32'(m_bdout));
        check("oe_drive_overlap", 32'(!sram_oe_n && drv), 32'(0));
        check("we_oe_overlap", 32'(!sram_oe_n && !sram_we_n), 32'(0));
        if ((k >= 1) && m_we) check("wr_data", 32'(sram_d), 32'(m_din));
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_a(input logic we, input logic [9:0] addr, input logic [7:0] din,
                         output int lat, output int wlow);
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_din = din;
        lat = 0; wlow = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sram_ce_n || lat > 0) lat++;
            if (!sram_we_n) wlow++;
            if (bus.a_ack) break;
        end
        if (!bus.a_ack) fail_timeout("a_txn");
        bus.a_req = 1'b0;
    endtask

    function automatic logic [9:0] pick_addr();
        case ($urandom_range(3))
            0:       return 10'h000;
            1:       return 10'h3FF;
            2:       return 10'h155;
            default: return 10'h200 | 10'($urandom_range(15));
        endcase
    endfunction

    initial begin
        int lat, wlow, nack, a_wait, b_wait;
        logic [3:0] order;
        logic [7:0] b_first, before_3ff;

        for (int i = 0; i < 1024; i++) begin
            smem[i] = 8'(i * 7) ^ 8'h5A;
            mmem[i] = 8'(i * 7) ^ 8'h5A;
        end
        rst = 1'b1;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'h012; bus.a_din = 8'h00;
        bus.b_req = 1'b1; bus.b_addr = 10'h034;

        // reset with both requests high
        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(sram_ce_n), 32'(1));
        check("rst_a_dout", 32'(bus.a_dout), 32'(0));
        check("rst_b_ack", 32'(bus.b_ack), 32'(0));
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // A write then A read of 0x155
        run_a(1'b1, 10'h155, 8'hA5, lat, wlow);
        check("wr_latency", 32'(lat), 32'(5));
        check("wr_we_low_cycles", 32'(wlow), 32'(3));
        run_a(1'b0, 10'h155, 8'h00, lat, wlow);
        check("rd_latency", 32'(lat), 32'(5));
        check("rd_a_dout", 32'(bus.a_dout), 32'(8'hA5));

        // fresh reset, then both ports ask together and keep asking
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'h155;
        bus.b_req = 1'b1; bus.b_addr = 10'h155;
        nack = 0; order = '0; b_first = '0;
        for (int i = 0; i < 60 && nack < 4; i++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) begin
                if (nack == 0) b_first = bus.b_dout;
                order = {order[2:0], bus.b_ack};
                nack++;
            end
        end
        if (nack < 4) fail_timeout("alternation");
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        check("grant_order_BABA", 32'(order), 32'(4'b1010));
        check("b_first_dout", 32'(b_first), 32'(8'hA5));
        repeat (2) @(negedge clk);

        // reset in the 2nd ACCESS cycle of a write aborts it
        before_3ff = smem[10'h3FF];
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 10'h3FF; bus.a_din = 8'h5A;
        for (int i = 0; i < 20 && sram_we_n; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.a_req = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(sram_we_n), 32'(1));
        check("abort_drive", 32'(dut.sram_d_oe_q), 32'(0));
        rst = 1'b0;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.a_ack) nack++;
        end
        check("abort_no_ack", 32'(nack), 32'(0));
        check("abort_mem_3ff", 32'(smem[10'h3FF]), 32'(before_3ff));

        // address extremes, no aliasing
        run_a(1'b1, 10'h000, 8'h11, lat, wlow);
        run_a(1'b1, 10'h3FF, 8'hEE, lat, wlow);
        run_a(1'b0, 10'h000, 8'h00, lat, wlow);
        check("rd_000", 32'(bus.a_dout), 32'(8'h11));
        run_a(1'b0, 10'h3FF, 8'h00, lat, wlow);
        check("rd_3ff", 32'(bus.a_dout), 32'(8'hEE));

        // random traffic on both ports
        a_wait = 0; b_wait = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (bus.a_req) begin
                a_wait++;
                if (bus.a_ack) bus.a_req = 1'b0;
                else if (a_wait > 40) begin fail_timeout("rand_a"); bus.a_req = 1'b0; end
            end else if (c < 560 && $urandom_range(2) == 0) begin
                bus.a_req = 1'b1; bus.a_we = 1'($urandom_range(1));
                bus.a_addr = pick_addr(); bus.a_din = 8'($urandom); a_wait = 0;
            end
            if (bus.b_req) begin
                b_wait++;
                if (bus.b_ack) bus.b_req = 1'b0;
                else if (b_wait > 40) begin fail_timeout("rand_b"); bus.b_req = 1'b0; end
            end else if (c < 560 && $urandom_range(2) == 0) begin
                bus.b_req = 1'b1; bus.b_addr = pick_addr(); b_wait = 0;
            end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
